// File: rtl/reg_wb_ctrl.sv
// Write-back controller: buffers ALU/memory results in a small FIFO and drives
// the register group's write port one registered write per clock.
module reg_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    output logic                     wb_ready,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [AW-1:0]            raa,
    output logic                     hazard,
    output logic                     we,
    output logic [AW-1:0]            rwba,
    output logic [DW-1:0]            i,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] NOREG = '1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] rwba_nxt;
    logic [DW-1:0] i_nxt;
    entry_t        head;
    logic          push;
    logic          pop;
    logic          hit;
    logic [PW-1:0] idx;

    assign wb_ready = (count < CW'(DEPTH));
    assign push     = wb_valid && wb_ready && !flush;
    assign pop      = (count != '0) && !stall && !flush;
    assign head     = mem[rd_ptr];
    assign we       = (state != WRITE);

    // NOTE: every variable gets a default before any branch so no latch is inferred.
    always_comb begin
        state_nxt = IDLE;
        rwba_nxt  = NOREG;
        i_nxt     = '0;
        if (pop && head.addr != NOREG) begin
            state_nxt = WRITE;
            rwba_nxt  = head.addr;
            i_nxt     = head.data;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rwba   <= NOREG;
            i      <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_nxt;
            rwba  <= rwba_nxt;
            i     <= i_nxt;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= '{addr: wb_addr, data: wb_data};
    end

    // Scan live entries from the head; a write on the bus is also still pending.
    always_comb begin
        hit = 1'b0;
        idx = rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count && mem[idx].addr == raa) hit = 1'b1;
        end
    end

    assign hazard = (raa != NOREG) && (hit || (state == WRITE && rwba == raa));

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Bench for reg_wb_ctrl: directed scenarios plus random traffic, checked against
// a queue-based model of the write-back buffer and write port.
module tb_reg_wb_ctrl;

    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       wb_ready;
    logic       stall;
    logic       flush;
    logic [1:0] raa;
    logic       hazard;
    logic       we;
    logic [1:0] rwba;
    logic [7:0] i;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    ent_t       q[$];
    logic       m_we   = 1'b1;
    logic [1:0] m_rwba = 2'b11;
    logic [7:0] m_i    = 8'h00;

    reg_wb_ctrl #(.DEPTH(DEPTH), .AW(2), .DW(8)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
        .stall(stall), .flush(flush), .raa(raa), .hazard(hazard),
        .we(we), .rwba(rwba), .i(i), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_hazard(input logic [1:0] r);
        if (r == 2'b11) return 1'b0;
        if (!m_we && m_rwba == r) return 1'b1;
        foreach (q[k]) if (q[k].addr == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: apply inputs at negedge, check combinational outputs, advance
    // the model across the posedge, then check the registered outputs.
    task automatic step(input logic v, input logic [1:0] a, input logic [7:0] d,
                        input logic s, input logic f, input logic [1:0] r, input logic rs);
        logic do_pop;
        logic do_push;
        ent_t h;
        wb_valid = v; wb_addr = a; wb_data = d;
        stall = s; flush = f; raa = r; rst = rs;
        #1;
        check("hazard", hazard, model_hazard(r));
        check("wb_ready", wb_ready, q.size() < DEPTH);
        m_we = 1'b1; m_rwba = 2'b11; m_i = 8'h00;
        if (rs || f) begin
            q.delete();
        end else begin
            do_pop  = (q.size() > 0) && !s;
            do_push = v && (q.size() < DEPTH);
            if (do_pop) begin
                h = q.pop_front();
                if (h.addr != 2'b11) begin
                    m_we = 1'b0; m_rwba = h.addr; m_i = h.data;
                end
            end
            if (do_push) q.push_back('{addr: a, data: d});
        end
        @(posedge clk);
        @(negedge clk);
        check("we", we, m_we);
        check("rwba", rwba, m_rwba);
        check("i", i, m_i);
        check("count", count, q.size());
    endtask

    task automatic idle_step();
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b11, 1'b0);
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        stall = 1'b0; flush = 1'b0; raa = 2'b11;
        @(negedge clk);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1);
        check("rst_we", we, 1'b1);
        check("rst_rwba", rwba, 2'b11);
        check("rst_count", count, 0);

        // Single push: write visible exactly one cycle later, for one cycle
        step(1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 2'b11, 1'b0);
        check("t1_not_yet", we, 1'b1);
        idle_step();
        check("t1_we", we, 1'b0);
        check("t1_rwba", rwba, 2'b01);
        check("t1_i", i, 8'h5A);
        idle_step();
        check("t1_after", we, 1'b1);

        // Back-to-back pushes
        step(1'b1, 2'b00, 8'h11, 1'b0, 1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 2'b11, 1'b0);
        check("t2_i0", i, 8'h11);
        step(1'b1, 2'b10, 8'h33, 1'b0, 1'b0, 2'b11, 1'b0);
        check("t2_i1", i, 8'h22);
        idle_step();
        check("t2_i2", i, 8'h33);
        idle_step();

        // Fill under stall, overflow attempt, drain, then wrap
        for (int k = 0; k < 5; k++) step(1'b1, 2'(k), 8'hA0 + 8'(k), 1'b1, 1'b0, 2'b11, 1'b0);
        check("t3_full", count, 4);
        check("t3_ready", wb_ready, 1'b0);
        for (int k = 0; k < 5; k++) idle_step();
        step(1'b1, 2'b10, 8'hC1, 1'b0, 1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b00, 8'hC2, 1'b0, 1'b0, 2'b11, 1'b0);
        check("t3_wrap0", i, 8'hC1);
        idle_step();
        check("t3_wrap1", i, 8'hC2);
        idle_step();

        // Hazard against a buffered entry
        step(1'b1, 2'b10, 8'h80, 1'b1, 1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b10, 1'b0);
        check("t4_hz_hit", hazard, 1'b1);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b01, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b11, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0);
        check("t4_hz_clear", hazard, 1'b0);

        // Discard address
        step(1'b1, 2'b11, 8'hFF, 1'b0, 1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b00, 8'h07, 1'b0, 1'b0, 2'b11, 1'b0);
        check("t5_discard", we, 1'b1);
        idle_step();
        check("t5_we", we, 1'b0);
        check("t5_i", i, 8'h07);

        // Flush with concurrent push, then reset mid-write
        for (int k = 0; k < 3; k++) step(1'b1, 2'b01, 8'h40 + 8'(k), 1'b1, 1'b0, 2'b11, 1'b0);
        step(1'b1, 2'b10, 8'h99, 1'b0, 1'b1, 2'b11, 1'b0);
        check("t6_flush_cnt", count, 0);
        check("t6_flush_we", we, 1'b1);
        idle_step();
        idle_step();
        for (int k = 0; k < 3; k++) step(1'b1, 2'b00, 8'h50 + 8'(k), 1'b0, 1'b0, 2'b11, 1'b0);
        check("t6_inflight", we, 1'b0);
        step(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1);
        check("t6_rst_we", we, 1'b1);
        check("t6_rst_cnt", count, 0);
        idle_step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 79) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_ctrl.md
Name: reg_wb_ctrl

Overview:
- Write-back controller: the writer end of the register group's write port (we active-low, rwba, i).
- Accepts results from the ALU and memory path over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one register write per clock, with outputs registered on posedge so they are stable at the register group's negedge write.
- Exports a hazard flag so decode can stall a read of a register with a write still pending.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 2, register address width (00=a, 01=b, 10=c, 11=no register/discard).
- DW, 8, data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- wb_valid  in  1  producer offers a result.
- wb_addr  in  AW  destination register.
- wb_data  in  DW  result value.
- wb_ready  out  1  FIFO can accept; equals (count < DEPTH).
- stall  in  1  hold: no pop and no new write issued.
- flush  in  1  discard all buffered entries.
- raa  in  AW  read address being decoded, for the hazard check.
- hazard  out  1  pending write to raa.
- we  out  1  register write enable, active-low, registered.
- rwba  out  AW  write address, registered.
- i  out  DW  write data, registered.
- count  out  clog2(DEPTH)+1  entries currently buffered.

Behaviour:
- Reset, synchronous on rst=1 at posedge:
  - count=0, read and write pointers=0.
  - FSM=IDLE.
  - we=1, rwba=2'b11, i=0.
- Idle output values (we=1, rwba=11, i=0): rwba=11 selects no register, so d reads 0.
- Push: wb_valid && wb_ready at posedge writes {wb_addr, wb_data} at the write pointer. wb_valid with wb_ready=0 is ignored, so overflow cannot occur. The producer holds its data until accepted.
- Pop: at posedge when count>0 && !stall && !flush, the head entry is removed.
  - Head addr != 11: FSM->WRITE; we=0, rwba=addr, i=data for exactly one cycle.
  - Head addr == 11: entry is discarded; FSM->IDLE, outputs idle.
- No pop (count==0 or stall): FSM->IDLE and outputs return to idle at that posedge. An in-flight write lasts exactly one cycle, and stall never extends it.
- FSM: IDLE <-> WRITE only. There is no separate STALL state; stall simply forces IDLE.
- Simultaneous push and pop is allowed at any count < DEPTH; count is unchanged. When full, no push occurs and pop proceeds.
- Latency: word accepted into an empty FIFO at posedge k (no stall) -> popped at posedge k+1 -> we=0 from k+1 to k+2 -> register group captures it at the intervening negedge.
- Ordering: strict FIFO. Two writes to the same register land in acceptance order.
- Pointers wrap modulo DEPTH.
- hazard (combinational) = raa != 11 && (any buffered entry has addr == raa, or (we==0 && rwba == raa)).
- flush at posedge:
  - count=0 and pointers reset.
  - Any push in the same cycle is dropped.
  - Outputs go idle.
  - Precedence: rst > flush > push/pop.
- rst mid-write: the write is cancelled (we=1 after that posedge). Buffered entries are lost.
- wb_ready is derived from the registered count, with no combinational path from wb_valid.

Test Plan:
1. Reset then a single push {01, 8'h5A} into an empty FIFO at posedge k -> we=0, rwba=01, i=5A during cycle k+1..k+2 only; we=1, rwba=11, i=00 afterwards; count returns to 0.
2. Back-to-back pushes {00,11},{01,22},{10,33} with stall=0 -> three consecutive one-cycle writes in that order; wb_ready stays 1.
3. stall=1 while pushing 4 entries -> count=4, wb_ready=0, 5th wb_valid ignored, we stays 1. Release stall -> 4 writes on 4 consecutive cycles, count 4->0; pointer wrap verified by pushing 2 more and checking their data.
4. Hazard: buffer {10,80} with stall=1, raa=10 -> hazard=1. raa=01 -> hazard=0. raa=11 -> hazard=0. After the write issues and completes -> hazard=0.
5. Discard address: push {11,FF} then {00,07} -> no write for FF (we stays 1 that cycle); next cycle we=0, rwba=00, i=07.
6. Flush with 3 entries buffered and wb_valid=1 in the same cycle -> next cycle count=0 and we=1, the concurrent push is not stored, and no writes follow. Repeat with rst asserted mid-write -> identical idle result.
